// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_sequencer_pkg;

    // Number of restoring iterations for a 32-bit operand.
    localparam int DIV_ITERS = 32;

    // Sequencer states: wait for a start, iterate, apply sign fix, pulse done.
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ITER,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    // div_inst[0] requests a signed op, div_inst[1] an unsigned op.
    // If both bits are set, the unsigned request takes priority.
    function automatic logic is_signed_op(input logic [1:0] inst);
        return inst[0] & ~inst[1];
    endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// try to subtract the divisor and keep the difference if it did not borrow.
module div_sequencer_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            q_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // The trial is one bit wider than the remainder so its top bit is the
    // borrow: set means the divisor did not fit and the remainder is restored.
    always_comb begin
        shifted = {rem_i, q_msb_i};
        trial   = shifted - {1'b0, divisor_i};
        q_bit_o = ~trial[XLEN];
        rem_o   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. Operands are
// reduced to magnitudes at start, divided unsigned over XLEN cycles, then
// the quotient and remainder signs are fixed in a single extra cycle.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = DIV_ITERS,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      div_inst,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            stall_o,
    output logic            div_last,
    output logic [XLEN-1:0] Qo,
    output logic [XLEN-1:0] Ro,
    output logic            RSIGN
);

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q;       // partial remainder
    logic [XLEN-1:0]  quo_q;       // dividend bits shifting out, quotient bits shifting in
    logic [XLEN-1:0]  dvs_q;       // divisor magnitude
    logic             qneg_q;
    logic             rneg_q;
    logic             dz_q;        // divisor was zero at start
    logic             div_last_q;
    logic [XLEN-1:0]  qo_q;
    logic [XLEN-1:0]  ro_q;
    logic             rsign_q;

    logic             start_accept;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [XLEN-1:0]  rem_d;
    logic             q_bit_d;

    // A start is taken only from IDLE, and a same-cycle flush cancels it.
    always_comb begin
        start_accept = (state_q == DIV_IDLE) && (div_inst != 2'b00) && !flush;
        op_signed    = is_signed_op(div_inst);
        a_neg        = op_signed & dividend[XLEN-1];
        b_neg        = op_signed & divisor[XLEN-1];
    end

    div_sequencer_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_i     (rem_q),
        .q_msb_i   (quo_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .q_bit_o   (q_bit_d)
    );

    // Sequencer FSM with operand, iteration and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            div_last_q <= 1'b0;
            qo_q       <= '0;
            ro_q       <= '0;
            rsign_q    <= 1'b0;
        end else begin
            div_last_q <= 1'b0;
            case (state_q)
                DIV_IDLE: begin
                    if (start_accept) begin
                        rem_q   <= '0;
                        quo_q   <= a_neg ? -dividend : dividend;
                        dvs_q   <= b_neg ? -divisor : divisor;
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        dz_q    <= (divisor == '0);
                        cnt_q   <= CNT_W'(XLEN);
                        state_q <= DIV_ITER;
                    end
                end
                DIV_ITER: begin
                    if (flush) begin
                        cnt_q   <= '0;
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= {quo_q[XLEN-2:0], q_bit_d};
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= DIV_FIX;
                        end
                    end
                end
                DIV_FIX: begin
                    if (flush) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        // A zero divisor yields an all-ones quotient regardless
                        // of sign; the remainder fix still restores the dividend.
                        qo_q       <= (qneg_q && !dz_q) ? -quo_q : quo_q;
                        ro_q       <= rneg_q ? -rem_q : rem_q;
                        rsign_q    <= rneg_q;
                        div_last_q <= 1'b1;
                        state_q    <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    // Stall covers the start cycle combinationally, then ITER and FIX.
    always_comb begin
        stall_o = start_accept || (state_q == DIV_ITER) || (state_q == DIV_FIX);
    end

    assign div_last = div_last_q;
    assign Qo       = qo_q;
    assign Ro       = ro_q;
    assign RSIGN    = rsign_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a vector table of divisions with
// hand-computed results, plus flush, ignored-start and mid-op reset sequences.
module tb_div_sequencer;

    logic        clk;
    logic        reset;
    logic [1:0]  div_inst;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        stall_o;
    logic        div_last;
    logic [31:0] Qo;
    logic [31:0] Ro;
    logic        RSIGN;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_q;
    logic [31:0] last_r;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        rs;
    } vec_t;

    vec_t vecs[11];

    div_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .div_inst (div_inst),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .stall_o  (stall_o),
        .div_last (div_last),
        .Qo       (Qo),
        .Ro       (Ro),
        .RSIGN    (RSIGN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Count div_last pulses over a window of cycles.
    task automatic watch_no_last(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (div_last === 1'b1) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    // Run one division from a start in cycle N; optionally inject a second
    // start request at cycle N+inject_k (0 = none).
    task automatic run_op(input vec_t v, input int idx, input int inject_k);
        int lat;
        int stall_bad;
        @(negedge clk);
        div_inst = v.op;
        dividend = v.a;
        divisor  = v.b;
        #1;
        chk("start_stall", 32'(stall_o), 32'd1);
        @(negedge clk);
        div_inst = 2'b00;
        dividend = $urandom;
        divisor  = $urandom;
        lat       = 0;
        stall_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (div_last === 1'b1) begin
                lat = k;
                break;
            end
            if (stall_o !== 1'b1) stall_bad++;
            if (inject_k != 0 && k == inject_k) begin
                div_inst = 2'b01;
                dividend = 32'd1000;
                divisor  = 32'd10;
            end else begin
                div_inst = 2'b00;
            end
            @(negedge clk);
        end
        div_inst = 2'b00;
        chk("latency", 32'(lat), 32'd34);
        chk("stall_window", 32'(stall_bad), 32'd0);
        chk("stall_at_last", 32'(stall_o), 32'd0);
        chk("Qo", Qo, v.q);
        chk("Ro", Ro, v.r);
        chk("RSIGN", 32'(RSIGN), 32'(v.rs));
        $display("op %0d inst=%b a=%h b=%h Qo=%h Ro=%h RSIGN=%b latency=%0d",
                 idx, v.op, v.a, v.b, Qo, Ro, RSIGN, lat);
        last_q = v.q;
        last_r = v.r;
        @(negedge clk);
        chk("last_pulse_width", 32'(div_last), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{op: 2'b01, a: 32'd100,       b: 32'd7,         q: 32'd14,        r: 32'd2,         rs: 1'b0};
        vecs[1]  = '{op: 2'b01, a: 32'hFFFFFF9C,  b: 32'd7,         q: 32'hFFFFFFF2,  r: 32'hFFFFFFFE,  rs: 1'b1};
        vecs[2]  = '{op: 2'b10, a: 32'hFFFFFFFF,  b: 32'd16,        q: 32'h0FFFFFFF,  r: 32'd15,        rs: 1'b0};
        vecs[3]  = '{op: 2'b01, a: 32'd5,         b: 32'd0,         q: 32'hFFFFFFFF,  r: 32'd5,         rs: 1'b0};
        vecs[4]  = '{op: 2'b10, a: 32'd5,         b: 32'd0,         q: 32'hFFFFFFFF,  r: 32'd5,         rs: 1'b0};
        vecs[5]  = '{op: 2'b01, a: 32'h80000000,  b: 32'hFFFFFFFF,  q: 32'h80000000,  r: 32'd0,         rs: 1'b1};
        vecs[6]  = '{op: 2'b11, a: 32'hFFFFFFFF,  b: 32'd16,        q: 32'h0FFFFFFF,  r: 32'd15,        rs: 1'b0};
        vecs[7]  = '{op: 2'b01, a: 32'd100,       b: 32'hFFFFFFF9,  q: 32'hFFFFFFF2,  r: 32'd2,         rs: 1'b0};
        vecs[8]  = '{op: 2'b01, a: 32'hFFFFFFF9,  b: 32'd0,         q: 32'hFFFFFFFF,  r: 32'hFFFFFFF9,  rs: 1'b1};
        vecs[9]  = '{op: 2'b10, a: 32'h80000000,  b: 32'd3,         q: 32'h2AAAAAAA,  r: 32'd2,         rs: 1'b0};
        vecs[10] = '{op: 2'b01, a: 32'hFFFFFF9C,  b: 32'hFFFFFFF9,  q: 32'd14,        r: 32'hFFFFFFFE,  rs: 1'b1};

        reset    = 1'b1;
        div_inst = 2'b00;
        dividend = '0;
        divisor  = '0;
        flush    = 1'b0;
        last_q   = '0;
        last_r   = '0;
        repeat (3) @(negedge clk);
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_last", 32'(div_last), 32'd0);
        chk("reset_Qo", Qo, 32'd0);
        chk("reset_Ro", Ro, 32'd0);
        chk("reset_RSIGN", 32'(RSIGN), 32'd0);
        reset = 1'b0;

        // Table-driven divisions.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], i, 0);
        end

        // Flush at N+10: stall drops at N+11, no div_last, results untouched.
        @(negedge clk);
        div_inst = 2'b01;
        dividend = 32'd1234;
        divisor  = 32'd5;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            div_inst = 2'b00;
        end
        flush = 1'b1;
        #1;
        chk("flush_stall_same_cycle", 32'(stall_o), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_stall_next", 32'(stall_o), 32'd0);
        watch_no_last("flush_no_last", 40);
        chk("flush_Qo_kept", Qo, last_q);
        chk("flush_Ro_kept", Ro, last_r);
        $display("flush sequence Qo=%h Ro=%h", Qo, Ro);

        // Second start at N+5 is ignored; the first op completes normally.
        run_op(vecs[0], 100, 5);
        watch_no_last("ignored_start_no_extra_last", 40);

        // Flush and start in the same IDLE cycle: the start is dropped.
        @(negedge clk);
        div_inst = 2'b01;
        dividend = 32'd77;
        divisor  = 32'd7;
        flush    = 1'b1;
        #1;
        chk("flush_start_stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        div_inst = 2'b00;
        flush    = 1'b0;
        chk("flush_start_idle", 32'(stall_o), 32'd0);
        watch_no_last("flush_start_no_last", 40);
        $display("flush+start sequence stall=%b Qo=%h", stall_o, Qo);

        // Asynchronous reset at N+20, then a fresh op must complete.
        @(negedge clk);
        div_inst = 2'b01;
        dividend = 32'hFFFFFF9C;
        divisor  = 32'd7;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            div_inst = 2'b00;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_stall", 32'(stall_o), 32'd0);
        chk("midreset_last", 32'(div_last), 32'd0);
        chk("midreset_Qo", Qo, 32'd0);
        chk("midreset_Ro", Ro, 32'd0);
        chk("midreset_RSIGN", 32'(RSIGN), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_no_last("midreset_no_last", 40);
        $display("mid-op reset sequence Qo=%h Ro=%h", Qo, Ro);
        run_op(vecs[1], 101, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
